// File: rtl/el2_pkg.sv
// Shared types for the ICCM arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package el2_pkg;

   // Arbiter ownership states: fetch owns the ICCM, fetch is being drained, DMA owns the ICCM.
   typedef enum logic [1:0] {
      FETCH = 2'b00,
      DRAIN = 2'b01,
      DMA   = 2'b10
   } el2_iccm_arb_state_t;

   localparam int ARB_CNT_W = 8;

endpackage

// File: rtl/el2_iccm_arb_starve_cnt.sv
// Saturating 8-bit event counter with clear and a compare against a fixed limit.
// Latency: count updates one cycle after inc; at_limit is combinational from the count.
// Backpressure: none; clear wins over increment, count sticks at 255.
module el2_iccm_arb_starve_cnt
   import el2_pkg::*;
#(
   parameter int LIMIT = 14
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 inc,
   input  logic                 clr,
   output logic [ARB_CNT_W-1:0] cnt,
   output logic                 at_limit
);

   localparam logic [ARB_CNT_W-1:0] LIMIT_V = ARB_CNT_W'(LIMIT);
   localparam logic [ARB_CNT_W-1:0] CNT_MAX = '1;

   logic [ARB_CNT_W-1:0] cnt_next;

   // Next count: clear has priority, otherwise increment until saturation.
   always_comb begin
      cnt_next = cnt;
      if (clr)                        cnt_next = '0;
      else if (inc && cnt != CNT_MAX) cnt_next = cnt + 1'b1;
   end

   rvdff #(.WIDTH(ARB_CNT_W)) cnt_ff (
      .clk  (clk),
      .rst  (rst),
      .din  (cnt_next),
      .dout (cnt)
   );

   assign at_limit = (cnt == LIMIT_V);

endmodule

// File: rtl/el2_rvdff.sv
// Flop primitives with synchronous active-high reset: plain and enabled.
// Latency: one cycle from din to dout.
// Backpressure: none; rvdffs holds its value while en is low.
module rvdff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   // Capture din every cycle; reset clears to zero.
   always_ff @(posedge clk) begin
      if (rst) dout <= '0;
      else     dout <= din;
   end

endmodule

module rvdffs #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   // Capture din only when enabled; reset clears to zero.
   always_ff @(posedge clk) begin
      if (rst)     dout <= '0;
      else if (en) dout <= din;
   end

endmodule

// File: rtl/el2_ifu_iccm_arb.sv
// Single-port ICCM arbiter between IFU fetch (default owner) and DMA, with starvation-forced stall.
// Latency: DMA grant and ICCM access same cycle; read data/tag return one cycle after a read grant.
// Backpressure: DMA holds its request until granted; a starved DMA stalls fetch via dma_iccm_stall_any.
module el2_ifu_iccm_arb
   import el2_pkg::*;
#(
   parameter int ICCM_BITS      = 16,
   parameter int DMA_STARVE_MAX = 15,
   parameter int DMA_BURST_MAX  = 4,
   parameter int TAG_W          = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   ifc_fetch_req_bf,
   input  logic                   ifc_iccm_access_bf,
   input  logic [31:1]            ifc_fetch_addr_bf,
   input  logic                   ifc_dma_access_ok,
   input  logic                   dma_iccm_req,
   input  logic                   dma_iccm_write,
   input  logic [ICCM_BITS-1:0]   dma_iccm_addr,
   input  logic [63:0]            dma_iccm_wdata,
   input  logic [TAG_W-1:0]       dma_iccm_tag,
   output logic                   dma_iccm_gnt,
   output logic                   dma_iccm_stall_any,
   output logic                   dma_iccm_rvalid,
   output logic [TAG_W-1:0]       dma_iccm_rtag,
   output logic [63:0]            dma_iccm_rdata,
   output logic                   iccm_rden,
   output logic                   iccm_wren,
   output logic [ICCM_BITS-2:0]   iccm_rw_addr,
   output logic [63:0]            iccm_wr_data,
   input  logic [63:0]            iccm_rd_data
);

   el2_iccm_arb_state_t  state;
   el2_iccm_arb_state_t  state_next;
   logic [1:0]           state_q;
   logic                 in_fetch;
   logic                 in_dma;
   logic                 fetch_acc;
   logic                 gnt_raw;
   logic                 dma_exit;
   logic                 rd_gnt;
   logic                 starve_hit;
   logic                 burst_hit;
   logic [ARB_CNT_W-1:0] starve_cnt;
   logic [ARB_CNT_W-1:0] burst_cnt;
   logic                 unused_bits;

   assign state    = el2_iccm_arb_state_t'(state_q);
   assign in_fetch = (state == FETCH);
   assign in_dma   = (state == DMA);

   // Fetch cannot reach the ICCM while DMA owns it.
   assign fetch_acc = ifc_fetch_req_bf & ifc_iccm_access_bf & ~in_dma;

   // Grant: opportunistic in FETCH, unconditional in DMA, never while draining.
   always_comb begin
      gnt_raw = 1'b0;
      case (state)
         FETCH:   gnt_raw = dma_iccm_req & ifc_dma_access_ok;
         DMA:     gnt_raw = dma_iccm_req;
         default: gnt_raw = 1'b0;
      endcase
   end

   assign dma_iccm_gnt = gnt_raw & ~rst;
   assign dma_exit     = in_dma & (~dma_iccm_req | (burst_hit & gnt_raw));

   // Consecutive ungranted DMA cycles while fetch owns the array.
   el2_iccm_arb_starve_cnt #(.LIMIT(DMA_STARVE_MAX - 1)) starve_u (
      .clk      (clk),
      .rst      (rst),
      .inc      (in_fetch & dma_iccm_req & ~gnt_raw),
      .clr      (~in_fetch | ~dma_iccm_req | gnt_raw),
      .cnt      (starve_cnt),
      .at_limit (starve_hit)
   );

   // Grants issued within the current forced-stall window.
   el2_iccm_arb_starve_cnt #(.LIMIT(DMA_BURST_MAX - 1)) burst_u (
      .clk      (clk),
      .rst      (rst),
      .inc      (in_dma & gnt_raw),
      .clr      (~in_dma | dma_exit),
      .cnt      (burst_cnt),
      .at_limit (burst_hit)
   );

   // Ownership transitions; a dropped request always hands the array back to fetch.
   always_comb begin
      state_next = state;
      case (state)
         FETCH: if (dma_iccm_req & ~gnt_raw & starve_hit) state_next = DRAIN;
         DRAIN: begin
            if (~dma_iccm_req)          state_next = FETCH;
            else if (ifc_dma_access_ok) state_next = DMA;
         end
         DMA:   if (dma_exit) state_next = FETCH;
         default: state_next = FETCH;
      endcase
   end

   rvdff #(.WIDTH(2)) state_ff (
      .clk  (clk),
      .rst  (rst),
      .din  (state_next),
      .dout (state_q)
   );

   // Stall is registered so it is high exactly while DRAIN or DMA is the current state.
   rvdff #(.WIDTH(1)) stall_ff (
      .clk  (clk),
      .rst  (rst),
      .din  (state_next != FETCH),
      .dout (dma_iccm_stall_any)
   );

   // Read return pipeline: the array answers one cycle after a granted read.
   assign rd_gnt = dma_iccm_gnt & ~dma_iccm_write;

   rvdff #(.WIDTH(1)) rvalid_ff (
      .clk  (clk),
      .rst  (rst),
      .din  (rd_gnt),
      .dout (dma_iccm_rvalid)
   );

   rvdffs #(.WIDTH(TAG_W)) rtag_ff (
      .clk  (clk),
      .rst  (rst),
      .en   (rd_gnt),
      .din  (dma_iccm_tag),
      .dout (dma_iccm_rtag)
   );

   assign dma_iccm_rdata = dma_iccm_rvalid ? iccm_rd_data : 64'd0;

   // Array port mux: a DMA grant takes the port, otherwise fetch drives it.
   always_comb begin
      iccm_wr_data = dma_iccm_wdata;
      if (dma_iccm_gnt) begin
         iccm_rw_addr = dma_iccm_addr[ICCM_BITS-1:1];
         iccm_wren    = dma_iccm_write;
         iccm_rden    = ~dma_iccm_write;
      end else begin
         iccm_rw_addr = ifc_fetch_addr_bf[ICCM_BITS-1:1];
         iccm_wren    = 1'b0;
         iccm_rden    = fetch_acc & ~rst;
      end
   end

   assign unused_bits = ^{ifc_fetch_addr_bf[31:ICCM_BITS], dma_iccm_addr[0], starve_cnt, burst_cnt};

   // Fetch and DMA must never hit the single array port in the same cycle.
   collision_guard: assert property (@(posedge clk) disable iff (rst) !(dma_iccm_gnt && fetch_acc));

endmodule

// File: tb/tb_el2_ifu_iccm_arb.sv
// Self-checking bench for el2_ifu_iccm_arb with a behavioural ICCM and a read-return scoreboard.
// Latency: models a one-cycle ICCM read and a fetch controller that reacts to stall two cycles late.
// Backpressure: DMA requests are held until the DUT grants them.
module tb_el2_ifu_iccm_arb;
   import el2_pkg::*;

   localparam int IB = 16;
   localparam int SM = 15;
   localparam int BM = 4;
   localparam int TW = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          ifc_fetch_req_bf;
   logic          ifc_iccm_access_bf;
   logic [31:1]   ifc_fetch_addr_bf;
   logic          ifc_dma_access_ok;
   logic          dma_iccm_req;
   logic          dma_iccm_write;
   logic [IB-1:0] dma_iccm_addr;
   logic [63:0]   dma_iccm_wdata;
   logic [TW-1:0] dma_iccm_tag;
   logic          dma_iccm_gnt;
   logic          dma_iccm_stall_any;
   logic          dma_iccm_rvalid;
   logic [TW-1:0] dma_iccm_rtag;
   logic [63:0]   dma_iccm_rdata;
   logic          iccm_rden;
   logic          iccm_wren;
   logic [IB-2:0] iccm_rw_addr;
   logic [63:0]   iccm_wr_data;
   logic [63:0]   iccm_rd_data;

   typedef struct {
      logic [TW-1:0] tag;
      logic [63:0]   data;
   } ret_t;

   ret_t        exp_q[$];
   int          tests = 0;
   int          fails = 0;
   logic [63:0] mem [0:255];
   logic [63:0] rd_q;
   logic        stall_d;
   logic [7:0]  midx;

   always #5 clk = ~clk;

   el2_ifu_iccm_arb #(
      .ICCM_BITS(IB), .DMA_STARVE_MAX(SM), .DMA_BURST_MAX(BM), .TAG_W(TW)
   ) dut (
      .clk(clk), .rst(rst),
      .ifc_fetch_req_bf(ifc_fetch_req_bf), .ifc_iccm_access_bf(ifc_iccm_access_bf),
      .ifc_fetch_addr_bf(ifc_fetch_addr_bf), .ifc_dma_access_ok(ifc_dma_access_ok),
      .dma_iccm_req(dma_iccm_req), .dma_iccm_write(dma_iccm_write),
      .dma_iccm_addr(dma_iccm_addr), .dma_iccm_wdata(dma_iccm_wdata),
      .dma_iccm_tag(dma_iccm_tag), .dma_iccm_gnt(dma_iccm_gnt),
      .dma_iccm_stall_any(dma_iccm_stall_any), .dma_iccm_rvalid(dma_iccm_rvalid),
      .dma_iccm_rtag(dma_iccm_rtag), .dma_iccm_rdata(dma_iccm_rdata),
      .iccm_rden(iccm_rden), .iccm_wren(iccm_wren), .iccm_rw_addr(iccm_rw_addr),
      .iccm_wr_data(iccm_wr_data), .iccm_rd_data(iccm_rd_data)
   );

   function automatic logic [63:0] pat(input int k);
      return {32'hC0DE_0000 + 32'(k), ~32'(k)};
   endfunction

   // Behavioural ICCM (64-bit words, byte address [10:3]) plus fetch-side stall flop.
   assign midx         = iccm_rw_addr[9:2];
   assign iccm_rd_data = rd_q;
   always @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < 256; k++) mem[k] <= pat(k);
         stall_d <= 1'b0;
      end else begin
         if (iccm_wren) mem[midx] <= iccm_wr_data;
         stall_d <= dma_iccm_stall_any;
      end
      if (iccm_rden) rd_q <= mem[midx];
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, got, want);
      end
   endtask

   task automatic push_exp(input logic [TW-1:0] t, input logic [63:0] d);
      ret_t e;
      e.tag  = t;
      e.data = d;
      exp_q.push_back(e);
   endtask

   // Every cycle: rvalid must be high exactly when a read was granted the cycle before.
   task automatic ret_check();
      ret_t e;
      chk("rvalid", 64'(dma_iccm_rvalid), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         chk("rtag", 64'(dma_iccm_rtag), 64'(e.tag));
         chk("rdata", dma_iccm_rdata, e.data);
      end else begin
         chk("rdata_idle", dma_iccm_rdata, 64'd0);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      ret_check();
   endtask

   task automatic set_req(input logic w, input logic [IB-1:0] a, input logic [TW-1:0] t, input logic [63:0] d);
      dma_iccm_req   = 1'b1;
      dma_iccm_write = w;
      dma_iccm_addr  = a;
      dma_iccm_tag   = t;
      dma_iccm_wdata = d;
   endtask

   task automatic fetch_busy();
      ifc_fetch_req_bf   = 1'b1;
      ifc_iccm_access_bf = 1'b1;
      ifc_dma_access_ok  = 1'b0;
   endtask

   task automatic fetch_idle();
      ifc_fetch_req_bf  = 1'b0;
      ifc_dma_access_ok = 1'b1;
   endtask

   // Hold a request against a busy fetch pipe for DMA_STARVE_MAX cycles; stall must then rise.
   task automatic starve_to_drain();
      for (int k = 0; k < SM; k++) begin
         #1;
         chk("starve_gnt", 64'(dma_iccm_gnt), 64'd0);
         chk("starve_stall", 64'(dma_iccm_stall_any), 64'd0);
         tick();
      end
      chk("drain_stall", 64'(dma_iccm_stall_any), 64'd1);
      chk("drain_state", 64'(dut.state), 64'(DRAIN));
   endtask

   task automatic drain_to_dma();
      fetch_idle();
      #1;
      chk("drain_nognt", 64'(dma_iccm_gnt), 64'd0);
      tick();
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic          pend;
      int            wt;
      logic [7:0]    ridx;

      ifc_fetch_req_bf   = 1'b0;
      ifc_iccm_access_bf = 1'b0;
      ifc_fetch_addr_bf  = '0;
      ifc_dma_access_ok  = 1'b1;
      dma_iccm_tag       = '0;
      set_req(1'b1, 16'h0010, 3'd1, 64'h1);

      // Reset: combinational enables forced low even with a grantable request.
      #1;
      chk("rst_gnt", 64'(dma_iccm_gnt), 64'd0);
      chk("rst_wren", 64'(iccm_wren), 64'd0);
      dma_iccm_write = 1'b0;
      #1;
      chk("rst_rden", 64'(iccm_rden), 64'd0);
      tick();
      tick();
      chk("rst_stall", 64'(dma_iccm_stall_any), 64'd0);
      chk("rst_rtag", 64'(dma_iccm_rtag), 64'd0);
      chk("rst_state", 64'(dut.state), 64'(FETCH));
      chk("rst_starve", 64'(dut.starve_cnt), 64'd0);
      chk("rst_burst", 64'(dut.burst_cnt), 64'd0);
      rst          = 1'b0;
      dma_iccm_req = 1'b0;

      // Idle grant: read 0x0040 tag 5, word index 8.
      fetch_idle();
      set_req(1'b0, 16'h0040, 3'd5, 64'h0);
      #1;
      chk("idle_gnt", 64'(dma_iccm_gnt), 64'd1);
      chk("idle_addr", 64'(iccm_rw_addr), 64'h0020);
      chk("idle_rden", 64'(iccm_rden), 64'd1);
      chk("idle_wren", 64'(iccm_wren), 64'd0);
      push_exp(3'd5, pat(8));
      tick();
      dma_iccm_req = 1'b0;

      // Fetch owns the port when no DMA is granted.
      fetch_busy();
      ifc_fetch_addr_bf = 31'h0ABC_1234;
      #1;
      chk("fetch_addr", 64'(iccm_rw_addr), 64'h1234);
      chk("fetch_rden", 64'(iccm_rden), 64'd1);
      chk("fetch_gnt", 64'(dma_iccm_gnt), 64'd0);
      tick();

      // Opportunistic write then read-back of the same word.
      fetch_idle();
      set_req(1'b1, 16'h0088, 3'd0, 64'hDEAD_BEEF_0123_4567);
      #1;
      chk("wr_gnt", 64'(dma_iccm_gnt), 64'd1);
      chk("wr_wren", 64'(iccm_wren), 64'd1);
      chk("wr_rden", 64'(iccm_rden), 64'd0);
      chk("wr_addr", 64'(iccm_rw_addr), 64'h0044);
      chk("wr_data", iccm_wr_data, 64'hDEAD_BEEF_0123_4567);
      tick();
      set_req(1'b0, 16'h0088, 3'd1, 64'h0);
      #1;
      chk("rb_gnt", 64'(dma_iccm_gnt), 64'd1);
      push_exp(3'd1, 64'hDEAD_BEEF_0123_4567);
      tick();
      dma_iccm_req = 1'b0;

      // Starvation: stall after 15 ungranted cycles, grant one cycle after ok returns.
      fetch_busy();
      set_req(1'b0, 16'h0100, 3'd2, 64'h0);
      starve_to_drain();
      #1;
      chk("drain_wait_gnt", 64'(dma_iccm_gnt), 64'd0);
      tick();
      chk("drain_hold", 64'(dma_iccm_stall_any), 64'd1);
      drain_to_dma();
      #1;
      chk("dma_gnt", 64'(dma_iccm_gnt), 64'd1);
      chk("dma_addr", 64'(iccm_rw_addr), 64'h0080);
      push_exp(3'd2, pat(32));
      tick();
      dma_iccm_req = 1'b0;
      #1;
      chk("dma_idle_stall", 64'(dma_iccm_stall_any), 64'd1);
      tick();
      chk("dma_exit_stall", 64'(dma_iccm_stall_any), 64'd0);

      // Request drops in the same cycle the limit would be hit: stay in FETCH.
      fetch_busy();
      set_req(1'b0, 16'h0100, 3'd2, 64'h0);
      for (int k = 0; k < SM - 1; k++) tick();
      dma_iccm_req = 1'b0;
      tick();
      chk("drop_lim_stall", 64'(dma_iccm_stall_any), 64'd0);
      chk("drop_lim_state", 64'(dut.state), 64'(FETCH));

      // Abort in DRAIN.
      set_req(1'b0, 16'h0110, 3'd3, 64'h0);
      starve_to_drain();
      dma_iccm_req = 1'b0;
      #1;
      chk("abort_gnt", 64'(dma_iccm_gnt), 64'd0);
      tick();
      chk("abort_stall", 64'(dma_iccm_stall_any), 64'd0);
      chk("abort_state", 64'(dut.state), 64'(FETCH));

      // Burst: 6 queued writes, only 4 back-to-back grants in the stall window.
      set_req(1'b1, 16'h0300, 3'd0, 64'hB000_0000_0000_0000);
      starve_to_drain();
      drain_to_dma();
      for (int k = 0; k < BM; k++) begin
         set_req(1'b1, 16'h0300 + 16'(8 * k), 3'd0, 64'hB000_0000_0000_0000 + 64'(k));
         #1;
         chk("burst_gnt", 64'(dma_iccm_gnt), 64'd1);
         chk("burst_wdata", iccm_wr_data, 64'hB000_0000_0000_0000 + 64'(k));
         tick();
      end
      chk("burst_end_stall", 64'(dma_iccm_stall_any), 64'd0);
      chk("burst_end_cnt", 64'(dut.burst_cnt), 64'd0);
      set_req(1'b1, 16'h0320, 3'd0, 64'hB000_0000_0000_0004);
      fetch_busy();
      #1;
      chk("burst5_wait", 64'(dma_iccm_gnt), 64'd0);
      tick();
      fetch_idle();
      #1;
      chk("burst5_gnt", 64'(dma_iccm_gnt), 64'd1);
      tick();
      set_req(1'b1, 16'h0328, 3'd0, 64'hB000_0000_0000_0005);
      #1;
      chk("burst6_gnt", 64'(dma_iccm_gnt), 64'd1);
      tick();
      set_req(1'b0, 16'h0308, 3'd3, 64'h0);
      #1;
      chk("burst_rb_gnt", 64'(dma_iccm_gnt), 64'd1);
      push_exp(3'd3, 64'hB000_0000_0000_0001);
      tick();
      dma_iccm_req = 1'b0;
      tick();

      // Reset one cycle after a read grant in DMA state.
      fetch_busy();
      set_req(1'b0, 16'h0208, 3'd6, 64'h0);
      starve_to_drain();
      drain_to_dma();
      #1;
      chk("rstb_gnt", 64'(dma_iccm_gnt), 64'd1);
      push_exp(3'd6, pat(65));
      tick();
      rst = 1'b1;
      #1;
      chk("rstb_gnt_forced", 64'(dma_iccm_gnt), 64'd0);
      tick();
      chk("rstb_state", 64'(dut.state), 64'(FETCH));
      chk("rstb_starve", 64'(dut.starve_cnt), 64'd0);
      chk("rstb_burst", 64'(dut.burst_cnt), 64'd0);
      chk("rstb_stall", 64'(dma_iccm_stall_any), 64'd0);
      rst          = 1'b0;
      dma_iccm_req = 1'b0;
      tick();

      // Random traffic against a fetch pipe that honours the stall two cycles late.
      pend = 1'b0;
      wt   = 0;
      ridx = '0;
      for (int c = 0; c < 10000; c++) begin
         ifc_fetch_req_bf   = stall_d ? 1'b0 : 1'($urandom_range(0, 1));
         ifc_iccm_access_bf = 1'($urandom_range(0, 1));
         ifc_fetch_addr_bf  = 31'($urandom);
         ifc_dma_access_ok  = stall_d ? 1'b1 :
                              ((ifc_fetch_req_bf & ifc_iccm_access_bf) ? 1'b0 : ($urandom_range(0, 5) == 0));
         if (!pend && $urandom_range(0, 2) == 0) begin
            pend = 1'b1;
            wt   = 0;
            ridx = 8'($urandom);
            set_req(1'($urandom_range(0, 1)), {5'd0, ridx, 3'd0}, TW'($urandom), {$urandom, $urandom});
         end
         dma_iccm_req = pend;
         #1;
         if (dma_iccm_gnt) begin
            chk("rnd_latency_ok", 64'(wt <= SM + 3), 64'd1);
            chk("rnd_collision", 64'(ifc_fetch_req_bf & ifc_iccm_access_bf & ~dma_iccm_stall_any), 64'd0);
            if (!dma_iccm_write) push_exp(dma_iccm_tag, mem[ridx]);
            pend = 1'b0;
         end else if (pend) begin
            wt++;
            if (wt > SM + 3) chk("rnd_wait_cycles", 64'(wt), 64'(SM + 3));
         end
         tick();
      end
      dma_iccm_req = 1'b0;
      tick();
      tick();
      chk("q_empty", 64'(exp_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
